// File: rtl/sindoku_board_ctrl.sv
// SINdoku board controller: arbitrates the board RAM port between
// single-cell player edits and a full-board check scan.
module sindoku_board_ctrl #(
    parameter int CELLS = 81,
    parameter int AW    = 7
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Ack,
    input  logic          EditReq,
    input  logic [3:0]    EditRow,
    input  logic [3:0]    EditCol,
    input  logic [3:0]    EditVal,
    input  logic          CheckReq,
    output logic          EditAck,
    output logic          EditRej,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [3:0]    ram_wdata,
    input  logic [3:0]    ram_rdata,
    input  logic [3:0]    sol_rdata,
    input  logic          given_rdata,
    output logic [6:0]    ErrCount,
    output logic [6:0]    EmptyCount,
    output logic          Solved,
    output logic          q_I,
    output logic          q_Play,
    output logic          q_Edit,
    output logic          q_Check,
    output logic          q_Done
);

    typedef enum logic [5:0] {
        S_I     = 6'b000001,
        S_PLAY  = 6'b000010,
        S_EDIT  = 6'b000100,
        S_WRITE = 6'b001000,
        S_CHECK = 6'b010000,
        S_DONE  = 6'b100000
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(CELLS - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [3:0]    wdata_q, wdata_d;
    logic          ack_q, ack_d;
    logic          rej_q, rej_d;
    logic [3:0]    val_q, val_d;
    logic [6:0]    err_q, err_d;
    logic [6:0]    empty_q, empty_d;
    logic          solved_q, solved_d;
    logic          pend_q, pend_d;
    logic          drain_q, drain_d;
    logic          cell_ok;
    logic [AW-1:0] cell_addr;

    assign cell_ok   = (EditRow <= 4'd8) && (EditCol <= 4'd8) && (EditVal <= 4'd9);
    assign cell_addr = AW'(EditRow) * AW'(9) + AW'(EditCol);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        ack_d    = 1'b0;
        rej_d    = 1'b0;
        val_d    = val_q;
        err_d    = err_q;
        empty_d  = empty_q;
        solved_d = solved_q;
        pend_d   = 1'b0;
        drain_d  = 1'b0;
        case (state_q)
            S_I: begin
                if (Start) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (CheckReq) begin
                    state_d  = S_CHECK;
                    addr_d   = '0;
                    err_d    = '0;
                    empty_d  = '0;
                    solved_d = 1'b0;
                // A request still high during its own ack cycle is the old one
                end else if (EditReq && !ack_q) begin
                    if (!cell_ok) begin
                        ack_d = 1'b1;
                        rej_d = 1'b1;
                    end else begin
                        addr_d  = cell_addr;
                        val_d   = EditVal;
                        state_d = S_EDIT;
                    end
                end
            end
            S_EDIT: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                ack_d   = 1'b1;
                rej_d   = given_rdata;
                we_d    = !given_rdata;
                if (!given_rdata) wdata_d = val_q;
                state_d = S_PLAY;
            end
            S_CHECK: begin
                if (pend_q) begin
                    if (ram_rdata == 4'd0)
                        empty_d = empty_q + 7'd1;
                    else if (ram_rdata != sol_rdata)
                        err_d = err_q + 7'd1;
                end
                if (drain_q) begin
                    solved_d = (err_d == 7'd0) && (empty_d == 7'd0);
                    state_d  = solved_d ? S_DONE : S_PLAY;
                end else begin
                    pend_d = 1'b1;
                    if (addr_q == LAST) drain_d = 1'b1;
                    else addr_d = addr_q + AW'(1);
                end
            end
            S_DONE: begin
                if (Ack) state_d = S_I;
            end
            default: state_d = S_I;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_I;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            rej_q    <= 1'b0;
            val_q    <= '0;
            err_q    <= '0;
            empty_q  <= '0;
            solved_q <= 1'b0;
            pend_q   <= 1'b0;
            drain_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            rej_q    <= rej_d;
            val_q    <= val_d;
            err_q    <= err_d;
            empty_q  <= empty_d;
            solved_q <= solved_d;
            pend_q   <= pend_d;
            drain_q  <= drain_d;
        end
    end

    assign ram_addr   = addr_q;
    assign ram_we     = we_q;
    assign ram_wdata  = wdata_q;
    assign EditAck    = ack_q;
    assign EditRej    = rej_q;
    assign ErrCount   = err_q;
    assign EmptyCount = empty_q;
    assign Solved     = solved_q;
    assign q_I        = (state_q == S_I);
    assign q_Play     = (state_q == S_PLAY);
    assign q_Edit     = (state_q == S_EDIT) || (state_q == S_WRITE);
    assign q_Check    = (state_q == S_CHECK);
    assign q_Done     = (state_q == S_DONE);

endmodule

// File: tb/tb_sindoku_board_ctrl.sv
// Directed bench for sindoku_board_ctrl with a behavioural board RAM,
// solution ROM and clue ROM, all with one-cycle read latency.
`timescale 1ns/1ps
module tb_sindoku_board_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Ack = 1'b0;
    logic       EditReq = 1'b0;
    logic [3:0] EditRow = '0;
    logic [3:0] EditCol = '0;
    logic [3:0] EditVal = '0;
    logic       CheckReq = 1'b0;
    logic       EditAck, EditRej;
    logic [6:0] ram_addr;
    logic       ram_we;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata = '0;
    logic [3:0] sol_rdata = '0;
    logic       given_rdata = 1'b0;
    logic [6:0] ErrCount, EmptyCount;
    logic       Solved;
    logic       q_I, q_Play, q_Edit, q_Check, q_Done;

    logic [3:0] board [0:127];
    logic [3:0] img   [0:127];
    logic [3:0] sol   [0:127];
    logic       giv   [0:127];
    logic       load = 1'b0;

    int tests = 0;
    int fails = 0;

    sindoku_board_ctrl #(.CELLS(81), .AW(7)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .EditReq(EditReq), .EditRow(EditRow), .EditCol(EditCol),
        .EditVal(EditVal), .CheckReq(CheckReq),
        .EditAck(EditAck), .EditRej(EditRej),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .sol_rdata(sol_rdata),
        .given_rdata(given_rdata),
        .ErrCount(ErrCount), .EmptyCount(EmptyCount), .Solved(Solved),
        .q_I(q_I), .q_Play(q_Play), .q_Edit(q_Edit),
        .q_Check(q_Check), .q_Done(q_Done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        ram_rdata   <= board[ram_addr];
        sol_rdata   <= sol[ram_addr];
        given_rdata <= giv[ram_addr];
        if (load) board <= img;
        else if (ram_we) board[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_board(input bit with_faults);
        for (int i = 0; i < 128; i++) img[i] = sol[i];
        if (with_faults) begin
            for (int k = 0; k < 10; k++) img[8*k] = 4'd0;
            img[1]  = 4'((sol[1] % 9) + 1);
            img[41] = 4'((sol[41] % 9) + 1);
            img[80] = 4'((sol[80] % 9) + 1);
        end
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic edit_txn(input string tag, input logic [3:0] r, input logic [3:0] c,
                            input logic [3:0] v, input logic [6:0] a, input bit rej);
        EditRow = r; EditCol = c; EditVal = v; EditReq = 1'b1;
        tick();
        chk({tag, " edit state"}, q_Edit, 1);
        chk({tag, " addr"}, ram_addr, a);
        tick();
        chk({tag, " write state"}, q_Edit, 1);
        chk({tag, " early ack"}, EditAck, 0);
        tick();
        EditReq = 1'b0;
        chk({tag, " ack"}, EditAck, 1);
        chk({tag, " rej"}, EditRej, rej);
        chk({tag, " we"}, ram_we, !rej);
        chk({tag, " we addr"}, ram_addr, a);
        if (!rej) chk({tag, " wdata"}, ram_wdata, v);
        chk({tag, " back to play"}, q_Play, 1);
        tick();
        chk({tag, " ack pulse"}, EditAck, 0);
        chk({tag, " we pulse"}, ram_we, 0);
    endtask

    task automatic scan(input string tag, input bit exp_done,
                        input logic [6:0] exp_empty, input logic [6:0] exp_err);
        int bad;
        CheckReq = 1'b1;
        tick();
        CheckReq = 1'b0;
        chk({tag, " check state"}, q_Check, 1);
        chk({tag, " addr0"}, ram_addr, 0);
        chk({tag, " no ack"}, EditAck, 0);
        bad = 0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (ram_addr !== 7'(k) || ram_we !== 1'b0 || q_Check !== 1'b1 || EditAck !== 1'b0)
                bad++;
        end
        chk({tag, " sweep"}, bad, 0);
        tick();
        chk({tag, " drain"}, q_Check, 1);
        tick();
        chk({tag, " done"}, q_Done, exp_done);
        chk({tag, " play"}, q_Play, !exp_done);
        chk({tag, " empty"}, EmptyCount, exp_empty);
        chk({tag, " err"}, ErrCount, exp_err);
        chk({tag, " solved"}, Solved, exp_done);
        chk({tag, " no ack end"}, EditAck, 0);
    endtask

    initial begin
        #200000;
        tests++;
        fails++;
        $display("FAIL watchdog: observed timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            sol[i] = (i < 81) ? 4'((i % 9) + 1) : 4'd0;
            giv[i] = 1'b0;
            img[i] = 4'd0;
        end
        giv[1] = 1'b1;
        tick();
        tick();
        chk("reset I", q_I, 1);
        chk("reset addr", ram_addr, 0);
        chk("reset we", ram_we, 0);
        chk("reset wdata", ram_wdata, 0);
        chk("reset ack", EditAck, 0);
        chk("reset rej", EditRej, 0);
        chk("reset err", ErrCount, 0);
        chk("reset empty", EmptyCount, 0);
        chk("reset solved", Solved, 0);
        Reset = 1'b0;
        load = 1'b1;
        tick();
        load = 1'b0;

        EditRow = 4'd0; EditCol = 4'd0; EditVal = 4'd2; EditReq = 1'b1;
        tick();
        tick();
        chk("idle edit ignored", EditAck, 0);
        chk("idle stays", q_I, 1);
        EditReq = 1'b0;

        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("start play", q_Play, 1);

        edit_txn("e00", 4'd0, 4'd0, 4'd2, 7'd0, 1'b0);
        chk("e00 board", board[0], 2);
        edit_txn("e23", 4'd2, 4'd3, 4'd5, 7'd21, 1'b0);
        chk("e23 board", board[21], 5);
        edit_txn("given", 4'd0, 4'd1, 4'd9, 7'd1, 1'b1);
        chk("given board", board[1], 0);

        EditRow = 4'd9; EditCol = 4'd3; EditVal = 4'd1; EditReq = 1'b1;
        tick();
        EditReq = 1'b0;
        chk("badrow ack", EditAck, 1);
        chk("badrow rej", EditRej, 1);
        chk("badrow addr", ram_addr, 1);
        chk("badrow we", ram_we, 0);
        chk("badrow play", q_Play, 1);
        tick();
        chk("badrow ack pulse", EditAck, 0);

        load_board(1'b1);
        scan("faulty", 1'b0, 7'd10, 7'd3);

        load_board(1'b0);
        EditRow = 4'd4; EditCol = 4'd4; EditVal = 4'd3; EditReq = 1'b1;
        scan("solved", 1'b1, 7'd0, 7'd0);
        EditReq = 1'b0;
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        chk("ack idle", q_I, 1);
        chk("ack solved held", Solved, 1);
        chk("ack empty held", EmptyCount, 0);
        chk("ack err held", ErrCount, 0);

        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("restart play", q_Play, 1);
        load_board(1'b1);
        CheckReq = 1'b1;
        tick();
        CheckReq = 1'b0;
        repeat (40) tick();
        chk("mid addr", ram_addr, 40);
        chk("mid empty", EmptyCount, 5);
        chk("mid err", ErrCount, 1);
        Reset = 1'b1;
        #1;
        chk("arst I", q_I, 1);
        chk("arst we", ram_we, 0);
        chk("arst addr", ram_addr, 0);
        chk("arst empty", EmptyCount, 0);
        chk("arst err", ErrCount, 0);
        Reset = 1'b0;
        tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("post reset play", q_Play, 1);
        scan("rescan", 1'b0, 7'd10, 7'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sindoku_board_ctrl.md
Name: sindoku_board_ctrl

Overview:
- Controller for the 81-cell SINdoku board RAM.
- Arbitrates the board's single RAM port between player edit requests and a full-board check scan.
- Sequences the game: idle, play, edit, check, done.
- Sits between the user-input/debounce logic and the board RAM, solution ROM and clue-mask ROM; the display reads the board elsewhere.

Parameters:
- CELLS, 81, number of board cells (9x9), linear address = row*9+col
- AW, 7, address width

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high
- Start  in  1  leave idle, begin play
- Ack  in  1  acknowledge DONE, return to idle
- EditReq  in  1  level request to write one cell; held until EditAck
- EditRow  in  4  target row 0..8
- EditCol  in  4  target column 0..8
- EditVal  in  4  value 0..9 (0 = clear cell)
- CheckReq  in  1  level request to scan the board
- EditAck  out  1  one-cycle pulse, edit request finished
- EditRej  out  1  valid with EditAck; 1 = edit refused
- ram_addr  out  AW  shared address to board RAM, solution ROM and clue ROM
- ram_we  out  1  board RAM write enable
- ram_wdata  out  4  board RAM write data
- ram_rdata  in  4  board cell value, 1-cycle read latency
- sol_rdata  in  4  solution value, 1-cycle read latency
- given_rdata  in  1  1 = cell is a fixed clue, 1-cycle read latency
- ErrCount  out  7  filled cells that differ from the solution (last check)
- EmptyCount  out  7  cells equal to 0 (last check)
- Solved  out  1  last check found 0 errors and 0 empties
- q_I, q_Play, q_Edit, q_Check, q_Done  out  1 each  one-hot state flags

Behaviour:
- Reset values: state I; ram_addr=0; ram_we=0; ram_wdata=0; EditAck=0; EditRej=0; ErrCount=0; EmptyCount=0; Solved=0.
- State register is one-hot: I, PLAY, EDIT, WRITE, CHECK, DONE. q_Edit is asserted in both EDIT and WRITE. Any illegal encoding goes to I on the next clock.
- I:
  - Start=1 -> PLAY.
  - EditReq and CheckReq are ignored; no EditAck is issued.
- PLAY:
  - CheckReq has priority over EditReq when both are high. The edit stays pending and is served after the check if still held.
  - CheckReq=1 -> CHECK. ram_addr<=0; both counters clear to 0; Solved<=0.
  - EditReq=1 (and no CheckReq):
    - If EditRow>8, EditCol>8 or EditVal>9: EditAck=1 and EditRej=1 next cycle, state stays PLAY, no RAM access.
    - Otherwise: ram_addr<=EditRow*9+EditCol; latch EditVal; -> EDIT.
- EDIT (1 cycle): waits for given_rdata to return. -> WRITE.
- WRITE (1 cycle):
  - given_rdata=0: ram_we=1, ram_wdata=latched value, EditRej=0.
  - given_rdata=1: ram_we=0, EditRej=1.
  - EditAck=1 in both cases. -> PLAY.
  - Edit latency from request sampled to EditAck: 3 cycles.
  - The requester must drop EditReq on EditAck. If it is still high on the cycle after EditAck, it is a new request.
- CHECK:
  - ram_addr increments 0..80, one address per cycle. Data returns one cycle later.
  - Pipelined compare on returned data, one cycle behind the address:
    - ram_rdata==0 -> EmptyCount+1.
    - Otherwise, if ram_rdata!=sol_rdata -> ErrCount+1.
  - Scan length is 82 cycles (81 addresses plus 1 drain cycle).
  - On the drain cycle, Solved<=(final counts both 0).
  - Next state: DONE if solved, else PLAY.
  - Counters saturate at 81 by construction.
  - EditReq is not acknowledged during CHECK.
  - ram_we=0 throughout CHECK.
- DONE:
  - Counters and Solved are held.
  - Ack=1 -> I.
  - Counters and Solved keep their values in I and clear on the next CheckReq.
- Reset mid-edit or mid-check: immediate return to reset values. A write in progress is not completed (ram_we deasserts asynchronously).
- Start asserted outside I, and Ack asserted outside DONE, are ignored.

Test Plan:
- Reset, Start, then EditReq row 0 col 0 val 2 with given_rdata=0 -> ram_we pulse at addr 0, wdata 2, EditAck=1 with EditRej=0 3 cycles after request; back in PLAY.
- EditReq row 0 col 1 val 9 with given_rdata=1 -> no ram_we, EditAck=1 with EditRej=1.
- EditReq row 9 col 3 -> EditAck with EditRej=1 one cycle later, no RAM access, ram_addr unchanged.
- Board model with 10 zeros and 3 wrong cells, CheckReq -> ram_addr sweeps 0..80, after 82 cycles EmptyCount=10, ErrCount=3, Solved=0, state PLAY.
- Board equal to the solution, CheckReq and EditReq asserted simultaneously -> check runs first, Solved=1, DONE, edit not acked. Then Ack -> I with counts held.
- Reset asserted at cell 40 of a scan -> state I, ram_we=0 and counters 0 immediately. Start then CheckReq -> full scan restarts at address 0.
